// File: rtl/tmp_meas_pkg.sv
// Shared types and default constants for the temperature-sensor measurement scheduler.
package tmp_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RSTHOLD,
        SETTLE,
        COUNT,
        DONE,
        WAIT
    } state_t;

    localparam int DEF_RST_CYC    = 4;
    localparam int DEF_SETTLE_CYC = 64;
    localparam int DEF_WINDOW     = 256;
    localparam int DEF_CW         = 9;
    localparam int DEF_LOG2_NAVG  = 2;
    localparam int DEF_PW         = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tmp_meas_sched_if.sv
// Result handshake between the scheduler (master) and its consumer (slave).
interface tmp_meas_sched_if
    import tmp_meas_pkg::*;
#(
    parameter int CW = DEF_CW
) ();

    logic [CW-1:0] result_data;
    logic          result_valid;
    logic          result_ready;

    modport master (output result_data, output result_valid, input result_ready);
    modport slave  (input result_data, input result_valid, output result_ready);

endinterface

// File: rtl/tmp_edge_counter.sv
// Counts toggles of the sensor sink line; saturating counter with synchronous clear.
module tmp_edge_counter
    import tmp_meas_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_snk,
    input  logic          i_en,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt_now
);

    logic          r_snk_q;
    logic [CW-1:0] r_cnt;
    logic          w_evt;
    logic          w_sat;

    // Edge history runs every cycle so a window never opens on a stale edge.
    assign w_evt     = i_snk ^ r_snk_q;
    assign w_sat     = &r_cnt;
    assign o_cnt_now = (i_en && w_evt && !w_sat) ? r_cnt + 1'b1 : r_cnt;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snk_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_snk_q <= i_snk;
            r_cnt   <= i_clr ? '0 : o_cnt_now;
        end
    end

endmodule

// File: rtl/tmp_meas_sched.sv
// Measurement scheduler: resets and settles the sensor controller, counts snk
// toggles over 2^LOG2_NAVG windows and hands the averaged count to the consumer.
module tmp_meas_sched
    import tmp_meas_pkg::*;
#(
    parameter int RST_CYC    = DEF_RST_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int CW         = DEF_CW,
    parameter int LOG2_NAVG  = DEF_LOG2_NAVG,
    parameter int PW         = DEF_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cont_en,
    input  logic [PW-1:0] period,
    input  logic          sens_snk,
    output logic          sens_rst,
    output logic          busy,
    output logic          err_nopulse,
    tmp_meas_sched_if.master res
);

    localparam int NAVG = 1 << LOG2_NAVG;
    localparam int AW   = CW + LOG2_NAVG;
    localparam int WIW  = LOG2_NAVG + 1;
    localparam int TW   = max_int(max_int($clog2(RST_CYC + 1), $clog2(SETTLE_CYC + 1)),
                                  max_int($clog2(WINDOW + 1), PW));

    state_t          r_state;
    logic [TW-1:0]   r_cnt;
    logic [WIW-1:0]  r_win;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_data;
    logic            r_valid;
    logic            r_sens_rst;
    logic            r_busy;
    logic            r_err;

    logic            w_count_en;
    logic            w_win_last;
    logic [CW-1:0]   w_evt_cnt;
    logic [AW-1:0]   w_acc_sum;

    assign w_count_en = (r_state == COUNT);
    assign w_win_last = w_count_en && (r_cnt == TW'(WINDOW - 1));
    // The window total already includes an event landing on the last cycle.
    assign w_acc_sum  = r_acc + AW'(w_evt_cnt);

    tmp_edge_counter #(.CW(CW)) u_edge (
        .clk       (clk),
        .reset     (reset),
        .i_snk     (sens_snk),
        .i_en      (w_count_en),
        .i_clr     (w_win_last),
        .o_cnt_now (w_evt_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_win      <= '0;
            r_acc      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_sens_rst <= 1'b1;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start || cont_en) begin
                        r_state <= RSTHOLD;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_win   <= '0;
                        r_acc   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                RSTHOLD: begin
                    if (r_cnt == TW'(RST_CYC - 1)) begin
                        r_state    <= SETTLE;
                        r_cnt      <= '0;
                        r_sens_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == TW'(SETTLE_CYC - 1)) begin
                        r_state <= COUNT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                COUNT: begin
                    if (w_win_last) begin
                        r_cnt <= '0;
                        r_acc <= w_acc_sum;
                        r_win <= r_win + 1'b1;
                        if (w_evt_cnt == '0) r_err <= 1'b1;
                        if (r_win == WIW'(NAVG - 1)) begin
                            r_state    <= DONE;
                            r_data     <= CW'(w_acc_sum >> LOG2_NAVG);
                            r_valid    <= 1'b1;
                            r_sens_rst <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res.result_ready) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        if (cont_en) begin
                            r_state <= WAIT;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    // Dropping cont_en wins over an expiring period.
                    if (!cont_en) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == TW'(period)) begin
                        r_state <= RSTHOLD;
                        r_cnt   <= '0;
                        r_win   <= '0;
                        r_acc   <= '0;
                        r_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sens_rst         = r_sens_rst;
    assign busy             = r_busy;
    assign err_nopulse      = r_err;
    assign res.result_data  = r_data;
    assign res.result_valid = r_valid;

endmodule

// File: tb/tb_tmp_meas_sched.sv
// Self-checking bench for tmp_meas_sched: timeline-based reference model plus directed literal checks.
module tb_tmp_meas_sched;

    localparam int RST_CYC    = 4;
    localparam int SETTLE_CYC = 64;
    localparam int WINDOW     = 256;
    localparam int LOG2_NAVG  = 2;
    localparam int NAVG       = 4;
    localparam int CW         = 9;
    localparam int CMAX       = (1 << CW) - 1;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        cont_en  = 1'b0;
    logic        sens_snk = 1'b0;
    logic        ready    = 1'b1;
    logic [15:0] period   = '0;

    wire sens_rst, busy, err_nopulse;
    wire sens_rst_s, busy_s, err_s;

    tmp_meas_sched_if #(.CW(9)) bus ();
    tmp_meas_sched_if #(.CW(6)) bus_s ();
    assign bus.result_ready   = ready;
    assign bus_s.result_ready = ready;

    tmp_meas_sched dut (
        .clk(clk), .reset(reset), .start(start), .cont_en(cont_en), .period(period),
        .sens_snk(sens_snk), .sens_rst(sens_rst), .busy(busy), .err_nopulse(err_nopulse),
        .res(bus.master)
    );

    tmp_meas_sched #(.CW(6)) dut_s (
        .clk(clk), .reset(reset), .start(start), .cont_en(cont_en), .period(period),
        .sens_snk(sens_snk), .sens_rst(sens_rst_s), .busy(busy_s), .err_nopulse(err_s),
        .res(bus_s.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Sink stimulus: 0 = constant, 1 = toggle every cycle, 2 = toggle every 4 cycles.
    int snk_mode = 0;
    always @(posedge clk) begin
        #1;
        if (snk_mode == 1 || (snk_mode == 2 && cyc % 4 == 0)) sens_snk = ~sens_snk;
    end

    // Reference model: a measurement is one timeline of RST+SETTLE+WINDOW*NAVG cycles.
    typedef enum int {M_IDLE, M_MEAS, M_PRES, M_GAP} mphase_t;
    mphase_t m_ph;
    int      m_t, m_gap, m_data;
    int      m_wcnt[NAVG];
    logic    m_prev, m_err;

    always @(posedge clk or posedge reset) begin : model
        int   pos, w, now, sum;
        logic evt;
        if (reset) begin
            m_ph   <= M_IDLE;
            m_t    <= 0;
            m_gap  <= 0;
            m_prev <= 1'b0;
            m_data <= 0;
            m_err  <= 1'b0;
            for (int i = 0; i < NAVG; i++) m_wcnt[i] <= 0;
        end else begin
            evt = sens_snk ^ m_prev;
            m_prev <= sens_snk;
            case (m_ph)
                M_IDLE: if (start || cont_en) begin
                    m_ph  <= M_MEAS;
                    m_t   <= 0;
                    m_err <= 1'b0;
                    for (int i = 0; i < NAVG; i++) m_wcnt[i] <= 0;
                end
                M_MEAS: begin
                    m_t <= m_t + 1;
                    pos = m_t - RST_CYC - SETTLE_CYC;
                    if (pos >= 0) begin
                        w   = pos / WINDOW;
                        now = m_wcnt[w] + ((evt && m_wcnt[w] < CMAX) ? 1 : 0);
                        m_wcnt[w] <= now;
                        if (pos % WINDOW == WINDOW - 1 && now == 0) m_err <= 1'b1;
                        if (pos == WINDOW * NAVG - 1) begin
                            sum = now;
                            for (int i = 0; i < NAVG - 1; i++) sum += m_wcnt[i];
                            m_data <= sum / NAVG;
                            m_ph   <= M_PRES;
                        end
                    end
                end
                M_PRES: if (ready) begin
                    m_ph  <= cont_en ? M_GAP : M_IDLE;
                    m_gap <= 0;
                end
                M_GAP: begin
                    if (!cont_en) begin
                        m_ph <= M_IDLE;
                    end else if (m_gap == int'(period)) begin
                        m_ph  <= M_MEAS;
                        m_t   <= 0;
                        m_err <= 1'b0;
                        for (int i = 0; i < NAVG; i++) m_wcnt[i] <= 0;
                    end else begin
                        m_gap <= m_gap + 1;
                    end
                end
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_busy", busy, m_ph != M_IDLE);
            check("cyc_sens_rst", sens_rst, !(m_ph == M_MEAS && m_t >= RST_CYC));
            check("cyc_valid", bus.result_valid, m_ph == M_PRES);
            check("cyc_data", bus.result_data, m_data);
            check("cyc_err", err_nopulse, m_err);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int c);
        start = 1'b1;
        c = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int c_seen);
        int k = 0;
        @(negedge clk);
        while (!bus.result_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid_seen"}, bus.result_valid, 1'b1);
        c_seen = cyc;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c0, c1, h1, h2, h3, d;

        step(3);
        check("rst_sens_rst", sens_rst, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", bus.result_valid, 1'b0);
        check("rst_data", bus.result_data, 0);
        check("rst_err", err_nopulse, 1'b0);
        reset = 1'b0;
        step(2);

        // One-shot, toggle every 4 cycles: 64 events per window.
        snk_mode = 2;
        step(5);
        pulse_start(c0);
        wait_valid("oneshot", c1);
        check("oneshot_latency", c1 - c0, 1093);
        check("oneshot_data", bus.result_data, 64);
        check("oneshot_err", err_nopulse, 1'b0);
        @(negedge clk);
        check("oneshot_valid_1cyc", bus.result_valid, 1'b0);
        step(3);
        check("oneshot_idle", busy, 1'b0);

        // Toggle every cycle: 256 events/window, the CW=6 instance saturates at 63.
        snk_mode = 1;
        step(2);
        pulse_start(c0);
        wait_valid("sat", c1);
        check("sat_data_cw6", bus_s.result_data, 63);
        check("sat_data_cw9", bus.result_data, 256);
        step(3);

        // No events at all.
        snk_mode = 0;
        step(2);
        pulse_start(c0);
        wait_valid("zero", c1);
        check("zero_data", bus.result_data, 0);
        check("zero_err", err_nopulse, 1'b1);
        step(3);
        check("zero_err_sticky", err_nopulse, 1'b1);
        snk_mode = 2;
        pulse_start(c0);
        step(2);
        check("zero_err_clear", err_nopulse, 1'b0);
        wait_valid("zero_next", c1);
        check("zero_next_data", bus.result_data, 64);
        step(3);

        // Backpressure with a start pulse that must be ignored.
        ready = 1'b0;
        pulse_start(c0);
        wait_valid("bp", c1);
        d = bus.result_data;
        check("bp_data_val", d, 64);
        for (int i = 0; i < 50; i++) begin
            step();
            start = (i == 10);
            @(negedge clk);
            check("bp_valid", bus.result_valid, 1'b1);
            check("bp_data", bus.result_data, d);
            check("bp_sens_rst", sens_rst, 1'b1);
        end
        step();
        start = 1'b0;
        ready = 1'b1;
        step();
        check("bp_release", bus.result_valid, 1'b0);
        step(3);
        check("bp_idle", busy, 1'b0);

        // Continuous mode, period 10; drop cont_en in the middle of a COUNT phase.
        period  = 16'd10;
        cont_en = 1'b1;
        wait_valid("cont1", h1);
        step();
        wait_valid("cont2", h2);
        check("cont_spacing", h2 - h1, 1104);
        step(600);
        cont_en = 1'b0;
        wait_valid("cont3", h3);
        check("cont_last_spacing", h3 - h2, 1104);
        check("cont_last_data", bus.result_data, 64);
        step(4);
        check("cont_stop_idle", busy, 1'b0);

        // Asynchronous reset in the middle of COUNT, then a fresh measurement.
        pulse_start(c0);
        step(500);
        reset = 1'b1;
        #1;
        check("arst_sens_rst", sens_rst, 1'b1);
        check("arst_valid", bus.result_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        step(2);
        reset = 1'b0;
        step(2);
        pulse_start(c0);
        wait_valid("fresh", c1);
        check("fresh_latency", c1 - c0, 1093);
        check("fresh_data", bus.result_data, 64);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
